// File: rtl/ddram_loader.sv
// Write-side front end for the DDRAM byte-cache controller: pairs ioctl bytes
// into 16-bit words, queues them and issues them over the toggle handshake.
module ddram_loader #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [27:0] BASE       = 28'h0000000
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [26:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [27:0] wraddr,
    output logic [15:0] din,
    output logic        we_req,
    input  logic        we_ack,
    output logic        done,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 42;
    localparam logic [AW:0] WAIT_LVL = (AW+1)'(FIFO_DEPTH - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state;

    logic [7:0]    hold_lo;
    logic [25:0]   hold_addr;
    logic          hold_v;
    logic          dl_d;
    logic          dl_seen;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wp, rp, wp_nx, rp_nx, cnt_nx;
    logic          fifo_empty, fifo_full;
    logic          push, push_ok, pop, match;
    logic          hold_load, hold_clr;
    logic          done_cond;
    logic [EW-1:0] push_entry, rd_entry;

    assign match      = hold_v && (hold_addr == ioctl_addr[26:1]);
    assign fifo_empty = (wp == rp);
    assign fifo_full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign push_ok    = push && !fifo_full;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign wp_nx      = wp + {{AW{1'b0}}, push_ok};
    assign rp_nx      = rp + {{AW{1'b0}}, pop};
    assign cnt_nx     = wp_nx - rp_nx;
    assign rd_entry   = mem[rp[AW-1:0]];

    // A WAIT state whose ack already matches is a finished write, so done need
    // not wait for the FSM to step back into IDLE.
    assign done_cond = !ioctl_download && dl_seen && !hold_v && fifo_empty &&
                       (we_ack == we_req);

    // The hold register is only set by strobes, so flushing it whenever the
    // download is low and no strobe competes covers the falling edge.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        hold_load  = 1'b0;
        hold_clr   = 1'b0;
        if (ioctl_wr) begin
            if (!ioctl_addr[0]) begin
                hold_load = 1'b1;
                if (hold_v) begin
                    push       = 1'b1;
                    push_entry = {hold_addr, 8'h00, hold_lo};
                end
            end else if (match) begin
                push       = 1'b1;
                push_entry = {hold_addr, ioctl_dout, hold_lo};
                hold_clr   = 1'b1;
            end else begin
                push       = 1'b1;
                push_entry = {ioctl_addr[26:1], ioctl_dout, 8'h00};
            end
        end else if (!ioctl_download && hold_v) begin
            push       = 1'b1;
            push_entry = {hold_addr, 8'h00, hold_lo};
            hold_clr   = 1'b1;
        end
    end

    always_ff @(posedge DDRAM_CLK) begin
        if (push_ok) mem[wp[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            hold_lo    <= '0;
            hold_addr  <= '0;
            hold_v     <= 1'b0;
            wp         <= '0;
            rp         <= '0;
            dl_d       <= 1'b0;
            dl_seen    <= 1'b0;
            overflow   <= 1'b0;
            ioctl_wait <= 1'b0;
            done       <= 1'b0;
        end else begin
            dl_d       <= ioctl_download;
            wp         <= wp_nx;
            rp         <= rp_nx;
            ioctl_wait <= (cnt_nx >= WAIT_LVL);
            done       <= done_cond;
            if (hold_load) begin
                hold_lo   <= ioctl_dout;
                hold_addr <= ioctl_addr[26:1];
                hold_v    <= 1'b1;
            end else if (hold_clr) begin
                hold_v <= 1'b0;
            end
            if (ioctl_download)  dl_seen <= 1'b1;
            else if (done_cond)  dl_seen <= 1'b0;
            if (ioctl_download && !dl_d) overflow <= 1'b0;
            if (push && fifo_full)       overflow <= 1'b1;
        end
    end

    // Reset lands in WAIT so a write the controller still owes is let finish.
    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            state  <= S_WAIT;
            we_req <= 1'b0;
            wraddr <= '0;
            din    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        wraddr <= BASE + {1'b0, rd_entry[41:16], 1'b0};
                        din    <= rd_entry[15:0];
                        we_req <= ~we_req;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (we_ack == we_req) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddram_loader.sv
// Directed bench for ddram_loader: pairing, orphans, backpressure, overflow,
// reset mid-write and a randomly delayed acknowledge responder.
module tb_ddram_loader;
  localparam int DEPTH = 4;
  localparam logic [27:0] BASE = 28'h0100000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        we_ack = 1'b0;
  logic        ioctl_wait, we_req, done, overflow;
  logic [27:0] wraddr;
  logic [15:0] din;

  int checks = 0;
  int errors = 0;
  bit resp_en = 1'b0;
  int resp_max = 0;
  int toggles = 0;
  int base_toggles = 0;
  logic req_prev = 1'b0;
  logic [43:0] exp_q[$];
  logic [43:0] obs_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  ddram_loader #(.FIFO_DEPTH(DEPTH), .BASE(BASE)) dut (
    .DDRAM_CLK(clk),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .wraddr(wraddr),
    .din(din),
    .we_req(we_req),
    .we_ack(we_ack),
    .done(done),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // controller model: records each request, holds off a random time, acks
  initial begin
    logic [27:0] a;
    logic [15:0] d;
    logic        r;
    int          dly;
    forever begin
      @(negedge clk);
      if (resp_en && !reset && (we_req !== we_ack)) begin
        a = wraddr;
        d = din;
        r = we_req;
        dly = $urandom_range(resp_max, 0);
        obs_q.push_back({a, d});
        repeat (dly) begin
          @(negedge clk);
          chk("hold_wraddr", wraddr, a);
          chk("hold_din", din, d);
          chk("hold_req", we_req, r);
        end
        we_ack = r;
      end
    end
  end

  always @(negedge clk) begin
    if (we_req !== req_prev) toggles++;
    req_prev = we_req;
  end

  // driver tasks
  task automatic send_byte(input logic [26:0] a, input logic [7:0] d, input bit honour);
    int n = 0;
    while (honour && ioctl_wait && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (honour) chk("wait_bound", n < 500, 1);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic send_word(input logic [26:0] a, input logic [7:0] lo, input logic [7:0] hi,
                           input bit honour, input bit expect_it);
    send_byte(a, lo, honour);
    send_byte(a | 27'd1, hi, honour);
    if (expect_it) exp_q.push_back({BASE + {1'b0, a}, hi, lo});
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  // scoreboard comparison
  task automatic drain_compare(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk(tag, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_we_req", we_req, 0);
    chk("rst_wraddr", wraddr, 0);
    chk("rst_din", din, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // byte pairing and request latency
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(27'h0, 8'h11, 0);
    send_byte(27'h1, 8'h22, 0);
    chk("pair_latency", we_req, 0);
    @(negedge clk);
    chk("pair_req", we_req, 1);
    chk("pair_addr", wraddr, 28'h0100000);
    chk("pair_din", din, 16'h2211);
    ioctl_download = 1'b0;
    we_ack = 1'b1;
    @(negedge clk);
    chk("pair_done", done, 1);
    @(negedge clk);
    chk("pair_done_pulse", done, 0);

    // orphan bytes and end-of-download flush
    ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(27'h4, 8'hAA, 0);
    send_byte(27'h8, 8'hBB, 0);
    chk("orph_latency", we_req, 1);
    @(negedge clk);
    chk("orph_req", we_req, 0);
    chk("orph_addr", wraddr, 28'h0100004);
    chk("orph_din", din, 16'h00AA);
    ioctl_download = 1'b0;
    we_ack = 1'b0;
    @(negedge clk);
    chk("orph_no_done", done, 0);
    @(negedge clk);
    chk("orph2_req", we_req, 1);
    chk("orph2_addr", wraddr, 28'h0100008);
    chk("orph2_din", din, 16'h00BB);
    chk("orph2_no_done", done, 0);
    we_ack = 1'b1;
    @(negedge clk);
    chk("orph_done", done, 1);
    @(negedge clk);
    chk("orph_done_pulse", done, 0);

    // backpressure: source honours ioctl_wait
    ioctl_download = 1'b1;
    resp_max = 3;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      send_word(27'h20 + 27'(2 * k), 8'hA0 + 8'(k), 8'hB0 + 8'(k), 1, 1);
      if (k == 2) chk("bp_wait_lo", ioctl_wait, 0);
      if (k == 3) begin
        chk("bp_wait_hi", ioctl_wait, 1);
        resp_en = 1'b1;
      end
    end
    ioctl_download = 1'b0;
    wait_done("bp_done", 400);
    chk("bp_ovf", overflow, 0);
    chk("bp_wait_end", ioctl_wait, 0);
    drain_compare("bp_order");

    // overflow: source ignores ioctl_wait, sixth word is dropped
    resp_en = 1'b0;
    ioctl_download = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      send_word(27'h40 + 27'(2 * k), 8'hC0 + 8'(k), 8'hD0 + 8'(k), 0, k < 5);
      if (k == 3) chk("ovf_lo", overflow, 0);
    end
    chk("ovf_set", overflow, 1);
    resp_max = 2;
    resp_en = 1'b1;
    ioctl_download = 1'b0;
    wait_done("ovf_done", 400);
    chk("ovf_sticky", overflow, 1);
    drain_compare("ovf_data");
    ioctl_download = 1'b1;
    @(negedge clk);
    chk("ovf_clear", overflow, 0);
    ioctl_download = 1'b0;
    wait_done("ovf2_done", 20);

    // reset while a write with we_req=0 / we_ack=1 is outstanding
    resp_en = 1'b0;
    ioctl_download = 1'b1;
    @(negedge clk);
    send_word(27'h80, 8'h01, 8'h02, 0, 0);
    @(negedge clk);
    if (we_req === 1'b1) begin
      we_ack = 1'b1;
      send_word(27'h82, 8'h03, 8'h04, 0, 0);
      @(negedge clk);
    end
    chk("rw_setup", {we_req, we_ack}, 2'b01);
    send_word(27'h84, 8'h05, 8'h06, 0, 0);
    send_word(27'h86, 8'h07, 8'h08, 0, 0);
    ioctl_download = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rw_req_held", we_req, 0);
      chk("rw_done", done, 0);
      chk("rw_wait", ioctl_wait, 0);
    end
    chk("rw_wraddr", wraddr, 0);
    we_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rw_quiet", we_req, 0);
      chk("rw_quiet_done", done, 0);
    end

    // handshake hold under random acknowledge delays
    exp_q.delete();
    obs_q.delete();
    resp_max = 20;
    resp_en = 1'b1;
    base_toggles = toggles;
    ioctl_download = 1'b1;
    @(negedge clk);
    send_word(27'h100, 8'h5A, 8'hA5, 1, 1);
    send_word(27'h102, 8'h00, 8'hFF, 1, 1);
    send_word(27'h3FE, 8'h12, 8'h34, 1, 1);
    send_word(27'h7FFFFFE, 8'h80, 8'h01, 1, 1);
    send_word(27'h0, 8'hFF, 8'hFF, 1, 1);
    send_word(27'h200, 8'h69, 8'h96, 1, 1);
    ioctl_download = 1'b0;
    wait_done("hs_done", 2000);
    chk("hs_toggles", toggles - base_toggles, 6);
    drain_compare("hs_data");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
